// File: rtl/port_rd_frontend.sv
// rtl/port_rd_frontend.sv - egress read front end: queue scheduler, beat FIFO, packet framing
module port_rd_frontend (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ready,
   input  logic        wrr_enable,
   input  logic [7:0]  queue_empty,
   output logic        read_enable,
   output logic [2:0]  read_prior,
   input  logic        xfer_data_vld,
   input  logic [15:0] xfer_data,
   input  logic        end_of_packet,
   output logic        xfer_ready,
   output logic        rd_sop,
   output logic        rd_eop,
   output logic        rd_vld,
   output logic [15:0] rd_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] SEND = 2'd2;
   localparam logic [1:0] EOP  = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [2:0]  rnd;
   logic [7:0]  served;
   logic [15:0] fifo_data [16];
   logic [15:0] fifo_last;
   logic [3:0]  wptr;
   logic [3:0]  rptr;
   logic [4:0]  count;
   logic [4:0]  count_nxt;
   logic        last_out;
   logic [7:0]  eligible;
   logic        cand_vld;
   logic [2:0]  cand;
   logic        any_pending;
   logic        take;
   logic        advance_round;
   logic        push;
   logic        pop_en;

   assign any_pending   = ~&queue_empty;
   assign take          = (state == IDLE) && ready && cand_vld;
   assign advance_round = (state == IDLE) && ready && wrr_enable && !cand_vld && any_pending;
   // A full FIFO drops the beat; the SRAM side is expected to honour xfer_ready.
   assign push          = (state == SEND) && xfer_data_vld && (count != 5'd16);
   // Once the last beat has been moved to the output register, stop popping so
   // the EOP cycle follows that beat directly.
   assign pop_en        = (state == SEND) && (count != 5'd0) && !last_out;

   // Scheduler candidate: lowest-index eligible queue (strict or round-limited WRR).
   always_comb begin
      eligible = '0;
      cand     = 3'd0;
      for (int q = 0; q < 8; q++) begin
         if (wrr_enable)
            eligible[q] = !queue_empty[q] && !served[q] && (3'(q) <= (3'd7 - rnd));
         else
            eligible[q] = !queue_empty[q];
      end
      cand_vld = |eligible;
      for (int q = 7; q >= 0; q--) begin
         if (eligible[q])
            cand = 3'(q);
      end
   end

   // Next-state and next-count decode; outputs are registered from these.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = REQ;
         REQ:     state_nxt = SEND;
         SEND:    if (last_out) state_nxt = EOP;
         default: state_nxt = IDLE;
      endcase
      count_nxt = count;
      if (push && !pop_en)
         count_nxt = count + 5'd1;
      else if (!push && pop_en)
         count_nxt = count - 5'd1;
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wptr] <= xfer_data;
         fifo_last[wptr] <= end_of_packet;
      end
   end

   // Control state, scheduler bookkeeping, FIFO pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rnd         <= 3'd0;
         served      <= 8'd0;
         wptr        <= 4'd0;
         rptr        <= 4'd0;
         count       <= 5'd0;
         last_out    <= 1'b0;
         read_prior  <= 3'd0;
         read_enable <= 1'b0;
         rd_sop      <= 1'b0;
         rd_eop      <= 1'b0;
         rd_vld      <= 1'b0;
         rd_data     <= 16'd0;
         xfer_ready  <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         read_enable <= (state_nxt == REQ);
         rd_sop      <= (state_nxt == REQ);
         rd_eop      <= (state_nxt == EOP);
         xfer_ready  <= (state_nxt == SEND) && (count_nxt < 5'd14);
         rd_vld      <= pop_en;
         if (take) begin
            read_prior <= cand;
            if (wrr_enable)
               served[cand] <= 1'b1;
         end
         if (advance_round) begin
            rnd    <= rnd + 3'd1;
            served <= 8'd0;
         end
         if (push)
            wptr <= wptr + 4'd1;
         if (pop_en) begin
            rptr    <= rptr + 4'd1;
            rd_data <= fifo_data[rptr];
         end
         if (state_nxt != SEND)
            last_out <= 1'b0;
         else if (pop_en)
            last_out <= fifo_last[rptr];
      end
   end

endmodule

// File: doc/port_rd_frontend.md
PORT_RD_FRONTEND -- requirements
Module: port_rd_frontend

Interface
REQ-001 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ready  input  1  downstream can accept a new packet; sampled only in IDLE.
REQ-004 SHALL have wrr_enable  input  1  1 = weighted round robin, 0 = strict priority.
REQ-005 SHALL have queue_empty  input  8  bit q = 1 means priority queue q of this port is empty.
REQ-006 SHALL have read_enable  output  1  one-cycle dequeue request to the SRAM side.
REQ-007 SHALL have read_prior  output  3  queue index for read_enable; held until next request.
REQ-008 SHALL have xfer_data_vld  input  1  SRAM->port beat valid.
REQ-009 SHALL have xfer_data  input  16  SRAM->port beat payload.
REQ-010 SHALL have end_of_packet  input  1  marks last beat; valid only with xfer_data_vld.
REQ-011 SHALL have xfer_ready  output  1  buffer space available; SRAM side sends beats only while high.
REQ-012 SHALL have rd_sop, rd_eop, rd_vld  output  1 each  egress packet framing.
REQ-013 SHALL have rd_data  output  16  egress payload, valid when rd_vld = 1.

Function
REQ-014 SHALL implement FSM IDLE -> REQ -> SEND -> EOP -> IDLE.
REQ-015 In IDLE, when ready = 1 and a scheduler candidate exists, SHALL register candidate into read_prior and go to REQ.
REQ-016 In REQ (exactly 1 cycle), read_enable = 1 and rd_sop = 1, rd_vld = 0; next state SEND.
REQ-017 Strict priority (wrr_enable = 0): candidate = lowest-index q with queue_empty[q] = 0; queue 0 is highest priority.
REQ-018 WRR: 3-bit round counter r and 8-bit served mask; queue q eligible in round r iff q <= 7-r, queue_empty[q] = 0, served[q] = 0; candidate = lowest eligible index; served[q] set on REQ entry.
REQ-019 WRR: if IDLE has ready = 1 and some queue nonempty but no eligible candidate, SHALL increment r (7 wraps to 0), clear served mask, stay IDLE that cycle.
REQ-020 Result: over a full 8-round cycle with all queues backlogged, queue q is served 8-q times.
REQ-021 wrr_enable changes SHALL take effect only at IDLE decisions; r/served untouched while wrr_enable = 0.
REQ-022 SHALL contain a 16-entry x 16-bit FIFO plus 1-bit last flag per entry; beat written when xfer_data_vld = 1 and in SEND.
REQ-023 xfer_ready = 1 iff state is SEND and FIFO count < 14 (2 entries slack for in-flight beats); 0 in all other states.
REQ-024 In SEND, when FIFO non-empty, SHALL pop one entry per cycle and drive rd_vld = 1, rd_data = entry; rd_vld = 0 when FIFO empty (mid-packet gaps allowed).
REQ-025 Popped entry with last flag = 1: next state EOP; in EOP rd_eop = 1, rd_vld = 0 for exactly 1 cycle, then IDLE.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; FIFO pointers 4-bit, wrap modulo 16; count 5-bit.
REQ-027 Push with FIFO full SHALL be dropped and is a protocol error (assertion in bench); pop on empty never occurs.
REQ-028 Beats arriving outside SEND SHALL be ignored.
REQ-029 Next IDLE decision earliest in cycle after EOP; minimum packet-to-packet gap = sop 1 + data + eop 1 + idle 1.
REQ-030 All outputs SHALL be registered; read_enable/rd_sop rise 1 cycle after IDLE decision cycle; first rd_vld no earlier than 1 cycle after the first accepted beat.

Reset
REQ-031 rst_n = 0 SHALL force state IDLE, FIFO empty (pointers/count 0), r = 0, served = 0, read_prior = 0, and read_enable, rd_sop, rd_eop, rd_vld, xfer_ready = 0, rd_data = 0.
REQ-032 Reset mid-packet SHALL abort immediately with no rd_eop emitted; remaining SRAM beats ignored.

Verification
REQ-033 Strict: wrr_enable = 0, queue_empty = 8'b1111_0101, ready = 1 -> read_prior = 1 with single-cycle read_enable and rd_sop.
REQ-034 Packet: 4 beats 0xA001..0xA004, end_of_packet on 4th -> rd_sop, then 4 rd_vld cycles with identical data in order, then 1 rd_eop cycle, state IDLE.
REQ-035 WRR: wrr_enable = 1, all queues nonempty, ready held 1, 36 packets -> service counts q0..q7 = 8,7,6,5,4,3,2,1 in order 0-7,0-6,...,0.
REQ-036 Backpressure: 20-beat packet, egress pop stalled by forcing 15 beats in before first pop -> xfer_ready falls when count = 14; no beat lost or duplicated.
REQ-037 Boundary: queue_empty = 8'hFF with ready = 1 -> no read_enable, r unchanged; then ready = 0 with queue 3 nonempty -> no request.
REQ-038 Reset asserted at 2nd data beat of a packet -> next cycle all outputs 0, no rd_eop, FIFO count 0.
